pong_draw_controller: RTL and testbench
=======================================

PONG_DRAW_CONTROLLER -- requirements
Module: pong_draw_controller

Interface
REQ-001 Parameter FRAMES_PER_MOVE, default 1, SHALL set the number of completed wait periods between successive erase/move passes (legal 1..15).
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 go  input  1  start request, sampled only in S_IDLE.
REQ-005 fin_Wait, fin_B_D, fin_B_E, fin_P1_D, fin_P1_E, fin_P2_D, fin_P2_E  input  1 each  datapath done flags.
REQ-006 sel_out  output  2  shape select: 0 ball, 1 paddle 1, 2 paddle 2.
REQ-007 sel_col  output  2  colour select: 0 ball colour, 1 black, 2 paddle colour.
REQ-008 ld_bx, ld_by, ld_p1x, ld_p1y, ld_p2x, ld_p2y  output  1 each  origin register loads.
REQ-009 en_B_shapeCounter_D/E, en_P1_shapeCounter_D/E, en_P2_shapeCounter_D/E  output  1 each  shape counter enables.
REQ-010 en_delayCounter  output  1  delay counter run; low reloads the 1/60 s count.
REQ-011 plot  output  1  VGA pixel write enable.
REQ-012 frame_tick  output  1  one-cycle pulse per completed wait period.
REQ-013 state_out  output  4  current state encoding, for HEX display.

Function
REQ-014 States SHALL be S_IDLE, S_LOAD, S_DRAW_B, S_DRAW_P1, S_DRAW_P2, S_WAIT, S_RELOAD, S_ERASE_B, S_ERASE_P1, S_ERASE_P2.
REQ-015 All outputs except frame_tick SHALL be Moore decodes of the state register; at most one shape-counter enable SHALL be high in any cycle.
REQ-016 S_IDLE: all outputs 0; go=1 -> S_LOAD next cycle.
REQ-017 S_LOAD: all six ld_* = 1 for exactly one cycle, then unconditionally -> S_DRAW_B.
REQ-018 S_DRAW_X (X = B/P1/P2): sel_out = X code, sel_col = 0 for B, 2 for paddles, matching en_*_D = 1, plot = 1.
REQ-019 Draw order SHALL be B -> P1 -> P2 -> S_WAIT; a state exits the cycle after its fin_X_D is sampled high; the pixel of that cycle is plotted.
REQ-020 S_WAIT: en_delayCounter = 1, plot = 0; on fin_Wait = 1, frame_tick pulses and the 4-bit frame count increments.
REQ-021 In S_WAIT with fin_Wait = 1: if frame count = FRAMES_PER_MOVE-1, clear the count and go to S_ERASE_B; otherwise go to S_RELOAD.
REQ-022 S_RELOAD: en_delayCounter = 0 for exactly one cycle, then -> S_WAIT.
REQ-023 S_ERASE_X: sel_out = X code, sel_col = 1, matching en_*_E = 1, plot = 1; order B -> P1 -> P2 -> S_DRAW_B, each exit on fin_X_E.
REQ-024 Every state other than S_WAIT SHALL hold en_delayCounter = 0, so S_WAIT is always entered with a freshly reloaded count.
REQ-025 fin_* inputs not belonging to the current state SHALL be ignored; go outside S_IDLE SHALL be ignored.
REQ-026 A fin flag already high on state entry SHALL cause exit after one cycle (single-pixel pass); no stall.

Reset
REQ-027 reset = 1 at a clock edge SHALL force S_IDLE and clear the frame count, regardless of the current state (including mid-draw or mid-wait).
REQ-028 After reset, all outputs SHALL be 0, and state_out SHALL be 4'd0 (S_IDLE encoding), from the following cycle until go is accepted.

Configuration
REQ-029 With macro PONG_PAUSE_EN defined, an extra input pause (1 bit) SHALL exist; pause = 1 in S_WAIT SHALL hold S_WAIT with en_delayCounter = 0 and suppress frame_tick and count increment, and resume when pause returns to 0.
REQ-030 Without PONG_PAUSE_EN, the pause port SHALL be absent and S_WAIT SHALL behave per REQ-020/021.

Structure
REQ-031 Package pong_pkg SHALL hold the state encoding (S_IDLE = 0 through S_ERASE_P2 = 9, in REQ-014 order), the sel_out codes SEL_BALL/SEL_P1/SEL_P2, and the sel_col codes COL_BALL/COL_BLACK/COL_PADDLE.
REQ-032 The frame count SHALL live in one sub-module, pong_frame_counter (inputs clear and inc; outputs count and last).

Verification
REQ-033 Reset mid-S_DRAW_P1 -> next cycle state_out = 0 and all outputs 0; go = 1 -> one ld_* cycle, then S_DRAW_B.
REQ-034 go, with fin_B_D high after 16 cycles, fin_P1_D after 64, and fin_P2_D after 64 -> plot high for exactly 144 cycles, sel_out sequence 0,1,2, then en_delayCounter = 1.
REQ-035 FRAMES_PER_MOVE = 3, fin_Wait pulsed 3 times -> 3 frame_tick pulses, 2 S_RELOAD cycles with en_delayCounter = 0, then S_ERASE_B with sel_col = 1.
REQ-036 fin_P2_E held high on entry to S_ERASE_P2 -> exactly one plot cycle, then S_DRAW_B.
REQ-037 With PONG_PAUSE_EN defined, pause = 1 for 100 cycles in S_WAIT with fin_Wait = 1 -> no frame_tick and state unchanged; pause = 0 -> frame_tick the next cycle.
REQ-038 Stray fin_B_E = 1 during S_DRAW_P1 -> no state change and no enable glitch.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong draw controller: state encoding,
// shape-select and colour-select codes, frame counter width.
package pong_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_DRAW_B   = 4'd2,
        S_DRAW_P1  = 4'd3,
        S_DRAW_P2  = 4'd4,
        S_WAIT     = 4'd5,
        S_RELOAD   = 4'd6,
        S_ERASE_B  = 4'd7,
        S_ERASE_P1 = 4'd8,
        S_ERASE_P2 = 4'd9
    } state_t;

    localparam logic [1:0] SEL_BALL   = 2'd0;
    localparam logic [1:0] SEL_P1     = 2'd1;
    localparam logic [1:0] SEL_P2     = 2'd2;

    localparam logic [1:0] COL_BALL   = 2'd0;
    localparam logic [1:0] COL_BLACK  = 2'd1;
    localparam logic [1:0] COL_PADDLE = 2'd2;

    localparam int unsigned FRAME_CNT_W = 4;

endpackage

// File: rtl/pong_draw_controller_if.sv
// Handshake bundle between the pong draw controller and its datapath.
// The pause line exists only when PONG_PAUSE_EN is defined.
interface pong_draw_controller_if;
    import pong_pkg::*;

`ifdef PONG_PAUSE_EN
    logic pause;
`endif
    logic go;
    logic fin_Wait;
    logic fin_B_D;
    logic fin_B_E;
    logic fin_P1_D;
    logic fin_P1_E;
    logic fin_P2_D;
    logic fin_P2_E;
    logic [1:0] sel_out;
    logic [1:0] sel_col;
    logic ld_bx;
    logic ld_by;
    logic ld_p1x;
    logic ld_p1y;
    logic ld_p2x;
    logic ld_p2y;
    logic en_B_shapeCounter_D;
    logic en_B_shapeCounter_E;
    logic en_P1_shapeCounter_D;
    logic en_P1_shapeCounter_E;
    logic en_P2_shapeCounter_D;
    logic en_P2_shapeCounter_E;
    logic en_delayCounter;
    logic plot;
    logic frame_tick;
    logic [3:0] state_out;

    modport master (
`ifdef PONG_PAUSE_EN
        output pause,
`endif
        output go, fin_Wait, fin_B_D, fin_B_E, fin_P1_D, fin_P1_E, fin_P2_D, fin_P2_E,
        input  sel_out, sel_col, ld_bx, ld_by, ld_p1x, ld_p1y, ld_p2x, ld_p2y,
        input  en_B_shapeCounter_D, en_B_shapeCounter_E, en_P1_shapeCounter_D,
        input  en_P1_shapeCounter_E, en_P2_shapeCounter_D, en_P2_shapeCounter_E,
        input  en_delayCounter, plot, frame_tick, state_out
    );

    modport slave (
`ifdef PONG_PAUSE_EN
        input  pause,
`endif
        input  go, fin_Wait, fin_B_D, fin_B_E, fin_P1_D, fin_P1_E, fin_P2_D, fin_P2_E,
        output sel_out, sel_col, ld_bx, ld_by, ld_p1x, ld_p1y, ld_p2x, ld_p2y,
        output en_B_shapeCounter_D, en_B_shapeCounter_E, en_P1_shapeCounter_D,
        output en_P1_shapeCounter_E, en_P2_shapeCounter_D, en_P2_shapeCounter_E,
        output en_delayCounter, plot, frame_tick, state_out
    );

endinterface

// File: rtl/pong_frame_counter.sv
// Counts completed wait periods between erase/move passes; last flags
// the final period before the objects are moved.
module pong_frame_counter
    import pong_pkg::*;
#(
    parameter int unsigned FRAMES_PER_MOVE = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   inc,
    output logic [FRAME_CNT_W-1:0] count,
    output logic                   last
);

    localparam logic [FRAME_CNT_W-1:0] LAST_C = FRAME_CNT_W'(FRAMES_PER_MOVE - 1);

    logic [FRAME_CNT_W-1:0] count_r;

    // Frame count register: clear wins over increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {FRAME_CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {FRAME_CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == LAST_C);

endmodule

// File: rtl/pong_draw_controller.sv
// Pong draw/erase/wait sequencer. Optional macro PONG_PAUSE_EN adds a
// pause input that freezes the frame wait.
module pong_draw_controller
    import pong_pkg::*;
#(
    parameter int unsigned FRAMES_PER_MOVE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    pong_draw_controller_if.slave bus
);

    localparam logic [FRAME_CNT_W-1:0] LAST_C = FRAME_CNT_W'(FRAMES_PER_MOVE - 1);

    state_t state_r, next_s;
    logic   pause_s, wait_done_s, roll_s, last_s, frame_tick_r;
    logic [FRAME_CNT_W-1:0] frame_count_s;
    logic [1:0] sel_out_s, sel_col_s;
    logic ld_s, en_bd_s, en_be_s, en_p1d_s, en_p1e_s, en_p2d_s, en_p2e_s;
    logic en_delay_s, plot_s;

`ifdef PONG_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    assign wait_done_s = (state_r == S_WAIT) && bus.fin_Wait && !pause_s;
    // An out-of-range count (upset) is treated as the last period so it self-heals.
    assign roll_s = last_s || (frame_count_s > LAST_C);

    pong_frame_counter #(.FRAMES_PER_MOVE(FRAMES_PER_MOVE)) u_frame_counter (
        .clock (clock),
        .reset (reset),
        .clear (wait_done_s && roll_s),
        .inc   (wait_done_s && !roll_s),
        .count (frame_count_s),
        .last  (last_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Frame tick pulse, one cycle after the wait period is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= wait_done_s;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        next_s     = state_r;
        sel_out_s  = SEL_BALL;
        sel_col_s  = COL_BALL;
        ld_s       = 1'b0;
        en_bd_s    = 1'b0;
        en_be_s    = 1'b0;
        en_p1d_s   = 1'b0;
        en_p1e_s   = 1'b0;
        en_p2d_s   = 1'b0;
        en_p2e_s   = 1'b0;
        en_delay_s = 1'b0;
        plot_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.go) next_s = S_LOAD;
                else        next_s = S_IDLE;
            end
            S_LOAD: begin
                ld_s   = 1'b1;
                next_s = S_DRAW_B;
            end
            S_DRAW_B: begin
                sel_out_s = SEL_BALL;   sel_col_s = COL_BALL;
                en_bd_s   = 1'b1;       plot_s    = 1'b1;
                if (bus.fin_B_D) next_s = S_DRAW_P1;
                else             next_s = S_DRAW_B;
            end
            S_DRAW_P1: begin
                sel_out_s = SEL_P1;     sel_col_s = COL_PADDLE;
                en_p1d_s  = 1'b1;       plot_s    = 1'b1;
                if (bus.fin_P1_D) next_s = S_DRAW_P2;
                else              next_s = S_DRAW_P1;
            end
            S_DRAW_P2: begin
                sel_out_s = SEL_P2;     sel_col_s = COL_PADDLE;
                en_p2d_s  = 1'b1;       plot_s    = 1'b1;
                if (bus.fin_P2_D) next_s = S_WAIT;
                else              next_s = S_DRAW_P2;
            end
            S_WAIT: begin
                // A paused wait holds the delay counter in reload.
                en_delay_s = !pause_s;
                if (wait_done_s) begin
                    if (roll_s) next_s = S_ERASE_B;
                    else        next_s = S_RELOAD;
                end else begin
                    next_s = S_WAIT;
                end
            end
            S_RELOAD: begin
                next_s = S_WAIT;
            end
            S_ERASE_B: begin
                sel_out_s = SEL_BALL;   sel_col_s = COL_BLACK;
                en_be_s   = 1'b1;       plot_s    = 1'b1;
                if (bus.fin_B_E) next_s = S_ERASE_P1;
                else             next_s = S_ERASE_B;
            end
            S_ERASE_P1: begin
                sel_out_s = SEL_P1;     sel_col_s = COL_BLACK;
                en_p1e_s  = 1'b1;       plot_s    = 1'b1;
                if (bus.fin_P1_E) next_s = S_ERASE_P2;
                else              next_s = S_ERASE_P1;
            end
            S_ERASE_P2: begin
                sel_out_s = SEL_P2;     sel_col_s = COL_BLACK;
                en_p2e_s  = 1'b1;       plot_s    = 1'b1;
                if (bus.fin_P2_E) next_s = S_DRAW_B;
                else              next_s = S_ERASE_P2;
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    assign bus.sel_out              = sel_out_s;
    assign bus.sel_col              = sel_col_s;
    assign bus.ld_bx                = ld_s;
    assign bus.ld_by                = ld_s;
    assign bus.ld_p1x               = ld_s;
    assign bus.ld_p1y               = ld_s;
    assign bus.ld_p2x               = ld_s;
    assign bus.ld_p2y               = ld_s;
    assign bus.en_B_shapeCounter_D  = en_bd_s;
    assign bus.en_B_shapeCounter_E  = en_be_s;
    assign bus.en_P1_shapeCounter_D = en_p1d_s;
    assign bus.en_P1_shapeCounter_E = en_p1e_s;
    assign bus.en_P2_shapeCounter_D = en_p2d_s;
    assign bus.en_P2_shapeCounter_E = en_p2e_s;
    assign bus.en_delayCounter      = en_delay_s;
    assign bus.plot                 = plot_s;
    assign bus.frame_tick           = frame_tick_r;
    assign bus.state_out            = state_r;

endmodule

// File: tb/tb_pong_draw_controller.sv
// Directed bench for pong_draw_controller (FRAMES_PER_MOVE = 3); the pause
// scenario is built only when PONG_PAUSE_EN is defined.
module tb_pong_draw_controller;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    pong_draw_controller_if bus ();

    pong_draw_controller #(.FRAMES_PER_MOVE(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // {sel_out, sel_col, ld x6, en B_D,B_E,P1_D,P1_E,P2_D,P2_E, en_delayCounter, plot}
    logic [17:0] outs;
    assign outs = {bus.sel_out, bus.sel_col,
                   bus.ld_bx, bus.ld_by, bus.ld_p1x, bus.ld_p1y, bus.ld_p2x, bus.ld_p2y,
                   bus.en_B_shapeCounter_D, bus.en_B_shapeCounter_E,
                   bus.en_P1_shapeCounter_D, bus.en_P1_shapeCounter_E,
                   bus.en_P2_shapeCounter_D, bus.en_P2_shapeCounter_E,
                   bus.en_delayCounter, bus.plot};

    localparam logic [17:0] O_ZERO     = 18'd0;
    localparam logic [17:0] O_LOAD     = {2'd0, 2'd0, 6'b111111, 6'b000000, 2'b00};
    localparam logic [17:0] O_DRAW_B   = {2'd0, 2'd0, 6'b000000, 6'b100000, 2'b01};
    localparam logic [17:0] O_DRAW_P1  = {2'd1, 2'd2, 6'b000000, 6'b001000, 2'b01};
    localparam logic [17:0] O_DRAW_P2  = {2'd2, 2'd2, 6'b000000, 6'b000010, 2'b01};
    localparam logic [17:0] O_WAIT     = {2'd0, 2'd0, 6'b000000, 6'b000000, 2'b10};
    localparam logic [17:0] O_ERASE_B  = {2'd0, 2'd1, 6'b000000, 6'b010000, 2'b01};
    localparam logic [17:0] O_ERASE_P1 = {2'd1, 2'd1, 6'b000000, 6'b000100, 2'b01};
    localparam logic [17:0] O_ERASE_P2 = {2'd2, 2'd1, 6'b000000, 6'b000001, 2'b01};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_fins();
        bus.fin_Wait = 1'b0; bus.fin_B_D = 1'b0; bus.fin_B_E = 1'b0;
        bus.fin_P1_D = 1'b0; bus.fin_P1_E = 1'b0; bus.fin_P2_D = 1'b0; bus.fin_P2_E = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_vec++;
        if (bus.state_out !== 4'd0) begin
            n_err++; $display("FAIL reset_state: got %0d expected 0", bus.state_out);
        end
        n_vec++;
        if (outs !== O_ZERO || bus.frame_tick !== 1'b0) begin
            n_err++; $display("FAIL reset_outs: got %h/%b expected 0/0", outs, bus.frame_tick);
        end
        reset = 1'b0;
        bus.fin_B_D = 1'b1; bus.fin_Wait = 1'b1;
        tick(); tick(); tick();
        clear_fins();
        n_vec++;
        if ({bus.state_out, outs} !== {4'd0, O_ZERO}) begin
            n_err++; $display("FAIL idle_hold: got %0d/%h expected 0/%h", bus.state_out, outs, O_ZERO);
        end
    endtask

    task automatic test_draw();
        int plot_cnt = 0;
        logic [3:0]  exp_st;
        logic [17:0] exp_o;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        n_vec++;
        if ({bus.state_out, outs} !== {4'd1, O_LOAD}) begin
            n_err++; $display("FAIL load: got %0d/%h expected 1/%h", bus.state_out, outs, O_LOAD);
        end
        for (int i = 1; i <= 144; i++) begin
            tick();
            if (i <= 16)      begin exp_st = 4'd2; exp_o = O_DRAW_B;  end
            else if (i <= 80) begin exp_st = 4'd3; exp_o = O_DRAW_P1; end
            else              begin exp_st = 4'd4; exp_o = O_DRAW_P2; end
            n_vec++;
            if ({bus.state_out, outs} !== {exp_st, exp_o}) begin
                n_err++; $display("FAIL draw_cycle_%0d: got %0d/%h expected %0d/%h", i, bus.state_out, outs, exp_st, exp_o);
            end
            if (bus.plot === 1'b1) plot_cnt++;
            bus.fin_B_D  = (i == 16);
            bus.fin_P1_D = (i == 80);
            bus.fin_P2_D = (i == 144);
        end
        tick();
        clear_fins();
        n_vec++;
        if ({bus.state_out, outs} !== {4'd5, O_WAIT}) begin
            n_err++; $display("FAIL draw_to_wait: got %0d/%h expected 5/%h", bus.state_out, outs, O_WAIT);
        end
        n_vec++;
        if (plot_cnt !== 144) begin
            n_err++; $display("FAIL plot_count: got %0d expected 144", plot_cnt);
        end
    endtask

    task automatic test_frame_wait();
        for (int p = 1; p <= 3; p++) begin
            tick(); tick();
            n_vec++;
            if ({bus.state_out, outs, bus.frame_tick} !== {4'd5, O_WAIT, 1'b0}) begin
                n_err++; $display("FAIL wait_hold_%0d: got %0d/%h/%b expected 5/%h/0", p, bus.state_out, outs, bus.frame_tick, O_WAIT);
            end
            bus.fin_Wait = 1'b1;
            tick();
            bus.fin_Wait = 1'b0;
            n_vec++;
            if (bus.frame_tick !== 1'b1) begin
                n_err++; $display("FAIL frame_tick_%0d: got %b expected 1", p, bus.frame_tick);
            end
            if (p < 3) begin
                n_vec++;
                if ({bus.state_out, outs} !== {4'd6, O_ZERO}) begin
                    n_err++; $display("FAIL reload_%0d: got %0d/%h expected 6/%h", p, bus.state_out, outs, O_ZERO);
                end
                tick();
                n_vec++;
                if ({bus.state_out, outs, bus.frame_tick} !== {4'd5, O_WAIT, 1'b0}) begin
                    n_err++; $display("FAIL rewait_%0d: got %0d/%h/%b expected 5/%h/0", p, bus.state_out, outs, bus.frame_tick, O_WAIT);
                end
            end else begin
                n_vec++;
                if ({bus.state_out, outs} !== {4'd7, O_ERASE_B}) begin
                    n_err++; $display("FAIL erase_entry: got %0d/%h expected 7/%h", bus.state_out, outs, O_ERASE_B);
                end
            end
        end
    endtask

    task automatic test_erase_single();
        bus.fin_P2_E = 1'b1; bus.fin_P1_D = 1'b1; bus.fin_B_D = 1'b1;
        tick();
        bus.fin_P1_D = 1'b0; bus.fin_B_D = 1'b0;
        n_vec++;
        if ({bus.state_out, outs} !== {4'd7, O_ERASE_B}) begin
            n_err++; $display("FAIL erase_b_stray: got %0d/%h expected 7/%h", bus.state_out, outs, O_ERASE_B);
        end
        bus.fin_B_E = 1'b1;
        tick();
        bus.fin_B_E = 1'b0; bus.fin_P1_E = 1'b1;
        n_vec++;
        if ({bus.state_out, outs} !== {4'd8, O_ERASE_P1}) begin
            n_err++; $display("FAIL erase_p1: got %0d/%h expected 8/%h", bus.state_out, outs, O_ERASE_P1);
        end
        tick();
        bus.fin_P1_E = 1'b0;
        n_vec++;
        if ({bus.state_out, outs} !== {4'd9, O_ERASE_P2}) begin
            n_err++; $display("FAIL erase_p2: got %0d/%h expected 9/%h", bus.state_out, outs, O_ERASE_P2);
        end
        tick();
        bus.fin_P2_E = 1'b0;
        n_vec++;
        if ({bus.state_out, outs} !== {4'd2, O_DRAW_B}) begin
            n_err++; $display("FAIL erase_to_draw: got %0d/%h expected 2/%h", bus.state_out, outs, O_DRAW_B);
        end
    endtask

    task automatic test_stray();
        bus.fin_B_D = 1'b1;
        tick();
        bus.fin_B_D = 1'b0;
        bus.fin_B_E = 1'b1; bus.fin_P2_D = 1'b1; bus.fin_Wait = 1'b1;
        bus.fin_P1_E = 1'b1; bus.go = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({bus.state_out, outs} !== {4'd3, O_DRAW_P1}) begin
                n_err++; $display("FAIL stray_p1_%0d: got %0d/%h expected 3/%h", k, bus.state_out, outs, O_DRAW_P1);
            end
            tick();
        end
        clear_fins();
        bus.go = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_st [5] = '{4'd6, 4'd5, 4'd6, 4'd5, 4'd7};
        logic       exp_tk [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.fin_P1_D = 1'b1; bus.fin_P2_D = 1'b1;
        tick(); tick();
        clear_fins();
        n_vec++;
        if ({bus.state_out, outs} !== {4'd5, O_WAIT}) begin
            n_err++; $display("FAIL b2b_wait: got %0d/%h expected 5/%h", bus.state_out, outs, O_WAIT);
        end
        bus.fin_Wait = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if ({bus.state_out, bus.frame_tick} !== {exp_st[k], exp_tk[k]}) begin
                n_err++; $display("FAIL b2b_step_%0d: got %0d/%b expected %0d/%b", k, bus.state_out, bus.frame_tick, exp_st[k], exp_tk[k]);
            end
        end
        bus.fin_Wait = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.fin_B_E = 1'b1; bus.fin_P1_E = 1'b1; bus.fin_P2_E = 1'b1;
        tick(); tick(); tick();
        clear_fins();
        bus.fin_B_D = 1'b1;
        tick();
        bus.fin_B_D = 1'b0;
        n_vec++;
        if (bus.state_out !== 4'd3) begin
            n_err++; $display("FAIL mid_p1: got %0d expected 3", bus.state_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({bus.state_out, outs, bus.frame_tick} !== {4'd0, O_ZERO, 1'b0}) begin
            n_err++; $display("FAIL mid_reset: got %0d/%h/%b expected 0/0/0", bus.state_out, outs, bus.frame_tick);
        end
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        n_vec++;
        if ({bus.state_out, outs} !== {4'd1, O_LOAD}) begin
            n_err++; $display("FAIL mid_load: got %0d/%h expected 1/%h", bus.state_out, outs, O_LOAD);
        end
        tick();
        n_vec++;
        if ({bus.state_out, outs} !== {4'd2, O_DRAW_B}) begin
            n_err++; $display("FAIL mid_draw_b: got %0d/%h expected 2/%h", bus.state_out, outs, O_DRAW_B);
        end
    endtask

`ifdef PONG_PAUSE_EN
    task automatic test_pause();
        bus.fin_B_D = 1'b1; bus.fin_P1_D = 1'b1; bus.fin_P2_D = 1'b1;
        tick(); tick(); tick();
        clear_fins();
        bus.pause = 1'b1; bus.fin_Wait = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            n_vec++;
            if ({bus.state_out, bus.en_delayCounter, bus.frame_tick} !== {4'd5, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL pause_%0d: got %0d/%b/%b expected 5/0/0", k, bus.state_out, bus.en_delayCounter, bus.frame_tick);
            end
        end
        bus.pause = 1'b0;
        tick();
        bus.fin_Wait = 1'b0;
        n_vec++;
        if ({bus.state_out, bus.frame_tick} !== {4'd6, 1'b1}) begin
            n_err++; $display("FAIL pause_resume: got %0d/%b expected 6/1", bus.state_out, bus.frame_tick);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.go = 1'b0;
`ifdef PONG_PAUSE_EN
        bus.pause = 1'b0;
`endif
        clear_fins();
        test_reset();
        test_draw();
        test_frame_wait();
        test_erase_single();
        test_stray();
        test_back_to_back();
        test_reset_mid();
`ifdef PONG_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
